// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store memory port.
package lsu_pkg;

    typedef enum logic [1:0] {
        BYTE    = 2'd0,
        HALF    = 2'd1,
        WORD    = 2'd2,
        ILLEGAL = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    function automatic logic [2:0] size_bytes(input size_e size);
        case (size)
            BYTE:    return 3'd1;
            HALF:    return 3'd2;
            WORD:    return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    // Low n bits set; n is at most 4 for any legal access.
    function automatic logic [3:0] byte_mask(input logic [2:0] n);
        case (n)
            3'd0:    return 4'b0000;
            3'd1:    return 4'b0001;
            3'd2:    return 4'b0011;
            3'd3:    return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Split detection, part-2 address/mask/data and load assembly with extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] addr,
    input  size_e       size,
    input  logic        zero_ext,
    input  logic [31:0] wdata,
    input  logic [31:0] part1,
    input  logic [31:0] part2,
    output logic        split,
    output logic [31:0] p2_addr,
    output logic [3:0]  p2_mask,
    output logic [31:0] p2_data,
    output logic [31:0] load_data
);

    logic [2:0]  nbytes_s;
    logic [2:0]  room_s;
    logic [2:0]  n1_s;
    logic [5:0]  shamt_s;
    logic [3:0]  size_mask_s;
    logic [3:0]  keep_mask_s;
    logic [31:0] keep_bits_s;
    logic [31:0] raw_s;

    assign nbytes_s    = size_bytes(size);
    assign room_s      = 3'd4 - {1'b0, addr[1:0]};
    assign split       = (nbytes_s > room_s);
    assign n1_s        = split ? room_s : nbytes_s;
    assign shamt_s     = {n1_s, 3'b000};
    assign size_mask_s = byte_mask(nbytes_s);

    assign p2_addr = {addr[31:2], 2'b00} + 32'd4;
    assign p2_mask = size_mask_s >> n1_s;
    assign p2_data = wdata >> shamt_s;

    // Part 1 contributes only its first n1 bytes; part 2 lands above them.
    assign keep_mask_s = byte_mask(n1_s);
    assign keep_bits_s = {{8{keep_mask_s[3]}}, {8{keep_mask_s[2]}},
                          {8{keep_mask_s[1]}}, {8{keep_mask_s[0]}}};
    assign raw_s       = (part1 & keep_bits_s) | (part2 << shamt_s);

    // Truncate to the access size and extend.
    always_comb begin
        case (size)
            BYTE:    load_data = zero_ext ? {24'd0, raw_s[7:0]}  : {{24{raw_s[7]}}, raw_s[7:0]};
            HALF:    load_data = zero_ext ? {16'd0, raw_s[15:0]} : {{16{raw_s[15]}}, raw_s[15:0]};
            WORD:    load_data = raw_s;
            default: load_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store port to a single-port word RAM: one access at a time, split
// across word boundaries, with a watchdog on missing RAM valids.
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 15
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_unsigned,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err,
    output logic        o_mem_rd,
    output logic        o_mem_wr,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_wrmask,
    output logic [31:0] o_mem_data,
    input  logic        i_mem_rd_valid,
    input  logic        i_mem_wr_valid,
    input  logic [31:0] i_mem_data
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

    state_e      state_r,      state_nxt_s;
    logic [31:0] addr_r,       addr_nxt_s;
    size_e       size_r,       size_nxt_s;
    logic        we_r,         we_nxt_s;
    logic        zext_r,       zext_nxt_s;
    logic [31:0] wdata_r,      wdata_nxt_s;
    logic        part_r,       part_nxt_s;
    logic [31:0] part1_r,      part1_nxt_s;
    logic [CW-1:0] wd_cnt_r,   wd_cnt_nxt_s;
    logic        mem_rd_r,     mem_rd_nxt_s;
    logic        mem_wr_r,     mem_wr_nxt_s;
    logic [31:0] mem_addr_r,   mem_addr_nxt_s;
    logic [3:0]  mem_mask_r,   mem_mask_nxt_s;
    logic [31:0] mem_data_r,   mem_data_nxt_s;
    logic        resp_valid_r, resp_valid_nxt_s;
    logic        resp_err_r,   resp_err_nxt_s;
    logic [31:0] resp_rdata_r, resp_rdata_nxt_s;

    logic        mem_hit_s;
    logic        split_s;
    logic [31:0] p2_addr_s;
    logic [3:0]  p2_mask_s;
    logic [31:0] p2_data_s;
    logic [31:0] load_data_s;

    assign mem_hit_s = we_r ? i_mem_wr_valid : i_mem_rd_valid;

    lsu_align u_align (
        .addr      (addr_r),
        .size      (size_r),
        .zero_ext  (zext_r),
        .wdata     (wdata_r),
        .part1     (part_r ? part1_r : i_mem_data),
        .part2     (part_r ? i_mem_data : 32'd0),
        .split     (split_s),
        .p2_addr   (p2_addr_s),
        .p2_mask   (p2_mask_s),
        .p2_data   (p2_data_s),
        .load_data (load_data_s)
    );

    // Next-state, RAM strobe and response decode.
    always_comb begin
        state_nxt_s      = state_r;
        addr_nxt_s       = addr_r;
        size_nxt_s       = size_r;
        we_nxt_s         = we_r;
        zext_nxt_s       = zext_r;
        wdata_nxt_s      = wdata_r;
        part_nxt_s       = part_r;
        part1_nxt_s      = part1_r;
        wd_cnt_nxt_s     = wd_cnt_r;
        mem_rd_nxt_s     = 1'b0;
        mem_wr_nxt_s     = 1'b0;
        mem_addr_nxt_s   = mem_addr_r;
        mem_mask_nxt_s   = mem_mask_r;
        mem_data_nxt_s   = mem_data_r;
        resp_valid_nxt_s = 1'b0;
        resp_err_nxt_s   = 1'b0;
        resp_rdata_nxt_s = 32'd0;
        case (state_r)
            IDLE: begin
                if (i_req_valid) begin
                    addr_nxt_s  = i_req_addr;
                    size_nxt_s  = size_e'(i_req_size);
                    we_nxt_s    = i_req_we;
                    zext_nxt_s  = i_req_unsigned;
                    wdata_nxt_s = i_req_wdata;
                    part_nxt_s  = 1'b0;
                    part1_nxt_s = 32'd0;
                    if (i_req_size == ILLEGAL) begin
                        state_nxt_s      = RESP;
                        resp_valid_nxt_s = 1'b1;
                        resp_err_nxt_s   = 1'b1;
                    end else begin
                        state_nxt_s    = ISSUE;
                        mem_rd_nxt_s   = ~i_req_we;
                        mem_wr_nxt_s   = i_req_we;
                        mem_addr_nxt_s = i_req_addr;
                        mem_mask_nxt_s = byte_mask(size_bytes(size_e'(i_req_size)));
                        mem_data_nxt_s = i_req_wdata;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                state_nxt_s  = WAIT;
                wd_cnt_nxt_s = '0;
            end
            WAIT: begin
                if (mem_hit_s) begin
                    // A split access re-enters ISSUE once, for the next word.
                    if (!part_r && split_s) begin
                        state_nxt_s    = ISSUE;
                        part_nxt_s     = 1'b1;
                        part1_nxt_s    = i_mem_data;
                        mem_rd_nxt_s   = ~we_r;
                        mem_wr_nxt_s   = we_r;
                        mem_addr_nxt_s = p2_addr_s;
                        mem_mask_nxt_s = p2_mask_s;
                        mem_data_nxt_s = p2_data_s;
                    end else begin
                        state_nxt_s      = RESP;
                        resp_valid_nxt_s = 1'b1;
                        resp_rdata_nxt_s = we_r ? 32'd0 : load_data_s;
                    end
                end else if (wd_cnt_r == WD_LAST) begin
                    state_nxt_s      = RESP;
                    resp_valid_nxt_s = 1'b1;
                    resp_err_nxt_s   = 1'b1;
                end else begin
                    wd_cnt_nxt_s = wd_cnt_r + CW'(1);
                end
            end
            RESP: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any access in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            addr_r       <= 32'd0;
            size_r       <= BYTE;
            we_r         <= 1'b0;
            zext_r       <= 1'b0;
            wdata_r      <= 32'd0;
            part_r       <= 1'b0;
            part1_r      <= 32'd0;
            wd_cnt_r     <= '0;
            mem_rd_r     <= 1'b0;
            mem_wr_r     <= 1'b0;
            mem_addr_r   <= 32'd0;
            mem_mask_r   <= 4'd0;
            mem_data_r   <= 32'd0;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= 32'd0;
        end else begin
            state_r      <= state_nxt_s;
            addr_r       <= addr_nxt_s;
            size_r       <= size_nxt_s;
            we_r         <= we_nxt_s;
            zext_r       <= zext_nxt_s;
            wdata_r      <= wdata_nxt_s;
            part_r       <= part_nxt_s;
            part1_r      <= part1_nxt_s;
            wd_cnt_r     <= wd_cnt_nxt_s;
            mem_rd_r     <= mem_rd_nxt_s;
            mem_wr_r     <= mem_wr_nxt_s;
            mem_addr_r   <= mem_addr_nxt_s;
            mem_mask_r   <= mem_mask_nxt_s;
            mem_data_r   <= mem_data_nxt_s;
            resp_valid_r <= resp_valid_nxt_s;
            resp_err_r   <= resp_err_nxt_s;
            resp_rdata_r <= resp_rdata_nxt_s;
        end
    end

    assign o_req_ready  = (state_r == IDLE);
    assign o_resp_valid = resp_valid_r;
    assign o_resp_rdata = resp_rdata_r;
    assign o_resp_err   = resp_err_r;
    assign o_mem_rd     = mem_rd_r;
    assign o_mem_wr     = mem_wr_r;
    assign o_mem_addr   = mem_addr_r;
    assign o_mem_wrmask = mem_mask_r;
    assign o_mem_data   = mem_data_r;

endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Initiator-side memory port between the core's load/store stage and the single-port synchronous word RAM. It accepts one byte, halfword or word load/store at a time and drives the RAM's read/write strobes, address, byte mask and data. It waits on the RAM's read/write valid flags and returns a sign- or zero-extended load result. Accesses that cross a word boundary are split into two RAM transactions, because the RAM only serves bytes up to the next word boundary. A watchdog turns a missing valid (unmapped address) into an error response.

## Interface
- `TIMEOUT`, default 15: wait cycles without a RAM valid before the access is aborted with an error.
- `clk` in 1: clock, all logic on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `i_req_valid` in 1: request present.
- `o_req_ready` out 1: port idle; a request is accepted when `i_req_valid && o_req_ready`.
- `i_req_we` in 1: 1 = store, 0 = load.
- `i_req_size` in 2: 0 = byte, 1 = half, 2 = word, 3 = illegal.
- `i_req_unsigned` in 1: zero-extend the load when set.
- `i_req_addr` in 32: byte address, any alignment.
- `i_req_wdata` in 32: store data, right-aligned.
- `o_resp_valid` out 1: one-cycle completion pulse. There is no response backpressure.
- `o_resp_rdata` out 32: extended load data; 0 for stores and errors.
- `o_resp_err` out 1: timeout or illegal size; qualified by `o_resp_valid`.
- `o_mem_rd` out 1: RAM read strobe.
- `o_mem_wr` out 1: RAM write strobe.
- `o_mem_addr` out 32: RAM byte address.
- `o_mem_wrmask` out 4: unshifted byte mask; the RAM shifts it by `addr[1:0]`.
- `o_mem_data` out 32: unshifted write data; the RAM shifts it.
- `i_mem_rd_valid` in 1: RAM read result valid.
- `i_mem_wr_valid` in 1: RAM write done.
- `i_mem_data` in 32: RAM read data, already shifted right by `8*addr[1:0]`.

## Operation
**States**
- IDLE → ISSUE on accept. The request is latched.
- IDLE → RESP directly on size 3, with err=1 and no RAM access.
- ISSUE lasts one cycle. Exactly one of `o_mem_rd`/`o_mem_wr` is high. Then → WAIT.
- WAIT keeps both strobes low.
  - On the matching valid: capture the part, then go to ISSUE (part 2 needed) or RESP.
- RESP pulses `o_resp_valid` for one cycle, then → IDLE.

**Address, mask and data rules**
- Address and data are held constant from ISSUE through the cycle the valid is seen. The RAM's read-data shift and valid gating are combinational on the current address.
- Let `b = addr[1:0]` and `nbytes = 1/2/4` by size.
- Part 1 size is `n1 = min(nbytes, 4-b)`. Split iff `nbytes > 4-b`.
- Part 1 drives `addr`, `wrmask = (1<<nbytes)-1`, `data = wdata`. The RAM shift truncates the excess bytes.
- Part 2 drives:
  - `addr = {addr[31:2],2'b00} + 4`
  - `wrmask = sizemask >> n1`
  - `data = wdata >> 8*n1`
- Load assembly: `raw = (part1 & bytemask(n1)) | (part2 << 8*n1)`, truncated to `nbytes`.
  - Sign-extend from bit `8*nbytes-1` unless `i_req_unsigned`.
  - Size 2 ignores `i_req_unsigned`.
- Split stores are not atomic. On a part-2 timeout, part 1 stays written and err=1.

**Watchdog**
- The counter clears in ISSUE and increments each WAIT cycle without a valid.
- When it reaches `TIMEOUT`, go → RESP with err=1 and rdata=0.
- Valids seen outside WAIT are ignored.

**Reset**
- Reset in any state returns to IDLE on the next edge.
- All outputs are 0 after reset; `o_req_ready` is 1 after reset.
- A request in flight is dropped without a response.

## Timing
- Accept at cycle t.
- Unsplit access:
  - `o_mem_*` strobe at t+1.
  - RAM valid at t+2.
  - `o_resp_valid` at t+3.
- Split access:
  - Strobes at t+1 and t+3.
  - Response at t+5.
- `o_req_ready` is 0 from t+1 until the cycle after the response.
- The earliest next accept is the cycle after RESP.
- Response outputs are registered. `o_req_ready` is decoded from the state register.

## Structure
- Package `lsu_pkg` holds:
  - `size_e` (BYTE/HALF/WORD/ILLEGAL)
  - `state_e` (IDLE/ISSUE/WAIT/RESP)
  - helper functions `size_bytes()` and `byte_mask(n)`
- Sub-module `lsu_align` is purely combinational. It computes:
  - split flag and `n1`
  - part-2 address, mask and data
  - load assembly and extension
- The FSM and watchdog stay in the top.

## Test plan
The bench RAM is mapped at 0. It holds word 0x100 = 0x88776655 and word 0x104 = 0xCCBBAA99.
- **Aligned word load:** `lw 0x100` → `o_mem_rd` at t+1 with addr 0x100; response at t+3 with rdata 0x88776655, err 0.
- **Byte loads:** `lb 0x103` → 0xFFFFFF88; `lbu 0x103` → 0x00000088; single RAM read each.
- **Split word load:** `lw 0x102` → reads at 0x102 (t+1) then 0x104 (t+3); response at t+5 with rdata 0xAA998877.
- **Split halfword store:** `sh 0x103` with wdata 0x1234 → part 1 addr 0x103, mask 0011, data 0x1234; part 2 addr 0x104, mask 0001, data 0x12. Readback: byte 0x103 = 0x34, 0x104 = 0x12, neighbours unchanged.
- **Timeout and illegal size:** with `TIMEOUT=4`, `lw 0xFFFF0000` (no valid returned) → err=1 and rdata=0 after 4 WAIT cycles, ready again the next cycle. Size 3 → err at t+1 with no `o_mem_*` strobe.
- **Reset mid-operation:** `rst_n` low during WAIT of a split load → all outputs 0, ready=1, no response. A following `lw 0x100` completes normally.
